// File: rtl/output_ram_pkg.sv
// Shared definitions for the result-collection memory.
package output_ram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  // Bits needed to index pairs in a memory of the given depth.
  function automatic int unsigned pair_bits(input int unsigned depth);
    return $clog2(depth) - 1;
  endfunction

  // Bits needed for a word count that can reach the full depth.
  function automatic int unsigned count_bits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/output_ram_pair_ram.sv
// r x n word store with one pair-write port and one registered pair-read port.
// Even address holds the first word of a pair, odd address the second.
module pair_ram
  import output_ram_pkg::*;
#(
  parameter int r = 16,
  parameter int n = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [$clog2(r)-2:0]    wa,
  input  logic [n-1:0]            d1,
  input  logic [n-1:0]            d2,
  input  logic [$clog2(r)-2:0]    ra,
  output logic [n-1:0]            q1,
  output logic [n-1:0]            q2,
  input  logic                    dump
);

  logic [n-1:0] mem [0:r-1];

  // Pair write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wa, 1'b0}] <= d1;
      mem[{wa, 1'b1}] <= d2;
    end
  end

  // Registered pair read; sees pre-write contents on a same-pair collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= '0;
      q2 <= '0;
    end else begin
      q1 <= mem[{ra, 1'b0}];
      q2 <= mem[{ra, 1'b1}];
    end
  end

endmodule

// File: rtl/output_ram.sv
// Result-collection memory: accepts pairs over valid/ready into consecutive
// even/odd addresses, flags completion, and offers a registered pair readback.
module output_ram
  import output_ram_pkg::*;
#(
  parameter int r = 16,
  parameter int n = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [n-1:0]         pi1,
  input  logic [n-1:0]         pi2,
  input  logic [$clog2(r)-2:0] rd_i,
  output logic [n-1:0]         po1,
  output logic [n-1:0]         po2,
  output logic [$clog2(r):0]   count,
  output logic                 full,
  output logic                 done
);

  localparam int PAIRS = r / 2;
  localparam int PW    = pair_bits(r);
  localparam int CW    = count_bits(r);

  state_t        state;
  logic [PW-1:0] ptr;
  logic          accept;

  // Ready depends on state alone; start in the same cycle discards the pair.
  always_comb begin
    wr_ready = (state == COLLECT);
    accept   = wr_ready & wr_valid & ~start & ~rst;
  end

  // Collection FSM with pointer, word count and completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      count <= '0;
      full  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= COLLECT;
            ptr   <= '0;
            count <= '0;
          end
        end
        COLLECT: begin
          if (start) begin
            ptr   <= '0;
            count <= '0;
          end else if (wr_valid) begin
            ptr   <= ptr + PW'(1);
            count <= count + CW'(2);
            if (ptr == PW'(PAIRS - 1)) begin
              state <= FULL;
              full  <= 1'b1;
              done  <= 1'b1;
            end
          end
        end
        FULL: begin
          if (start) begin
            state <= COLLECT;
            ptr   <= '0;
            count <= '0;
            full  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pair_ram #(
    .r (r),
    .n (n)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (accept),
    .wa   (ptr),
    .d1   (pi1),
    .d2   (pi2),
    .ra   (rd_i),
    .q1   (po1),
    .q2   (po2),
    .dump (done)
  );

endmodule

// File: tb/tb_output_ram.sv
// Randomized and directed bench for output_ram against a word-array model.
module tb_output_ram;

  localparam int R = 16;
  localparam int N = 16;
  localparam int PAIRS = R / 2;

  logic          clk = 1'b0;
  logic          rst, start, wr_valid, wr_ready, full, done;
  logic [N-1:0]  pi1, pi2, po1, po2;
  logic [2:0]    rd_i;
  logic [4:0]    count;

  int errors = 0;
  int checks = 0;

  output_ram #(.r(R), .n(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .pi1      (pi1),
    .pi2      (pi2),
    .rd_i     (rd_i),
    .po1      (po1),
    .po2      (po2),
    .count    (count),
    .full     (full),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference model: words as an array, collection as "words stored so far".
  int unsigned m_mem   [0:R-1];
  bit          m_known [0:R-1];
  bit          m_collecting, m_full, m_done, m_po_known;
  int unsigned m_words, m_po1, m_po2;
  bit          chk_en = 1'b0;

  initial for (int i = 0; i < R; i++) m_known[i] = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_collecting = 0; m_full = 0; m_done = 0;
      m_words = 0; m_po1 = 0; m_po2 = 0; m_po_known = 1;
    end else begin
      m_po_known = m_known[2*rd_i] && m_known[2*rd_i+1];
      m_po1 = m_mem[2*rd_i];
      m_po2 = m_mem[2*rd_i+1];
      m_done = 0;
      if (start) begin
        m_collecting = 1; m_full = 0; m_words = 0;
      end else if (m_collecting && wr_valid) begin
        m_mem[m_words] = pi1;   m_known[m_words] = 1;
        m_mem[m_words+1] = pi2; m_known[m_words+1] = 1;
        m_words += 2;
        if (m_words == R) begin
          m_collecting = 0; m_full = 1; m_done = 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_ready", wr_ready, m_collecting);
      check("count", count, m_words);
      check("full", full, m_full);
      check("done", done, m_done);
      if (m_po_known) begin
        check("po1", po1, m_po1);
        check("po2", po2, m_po2);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; start = 0; wr_valid = 0; pi1 = '0; pi2 = '0; rd_i = '0;
    tick();
    chk_en = 1;
    tick();
    rst = 0;

    // Idle ignores valid data.
    wr_valid = 1; pi1 = 5; pi2 = 6;
    repeat (3) tick();
    check("idle_ready", wr_ready, 0);
    check("idle_count", count, 0);
    check("idle_po1", po1, 0);
    check("idle_po2", po2, 0);

    // Full back-to-back collection.
    wr_valid = 0; start = 1; tick(); start = 0;
    for (int k = 0; k < PAIRS; k++) begin
      wr_valid = 1; pi1 = N'(2*k); pi2 = N'(2*k+1);
      tick();
      check("seq_count", count, 2*(k+1));
    end
    check("seq_done", done, 1);
    check("seq_full", full, 1);
    check("seq_ready", wr_ready, 0);
    wr_valid = 0; rd_i = 3; tick();
    check("seq_done_pulse", done, 0);
    check("seq_rd3_po1", po1, 6);
    check("seq_rd3_po2", po2, 7);

    // FULL ignores writes; restart overwrites pair 0 only.
    wr_valid = 1; pi1 = 16'hFFFF; pi2 = 16'hFFFF; rd_i = 0;
    repeat (3) tick();
    check("full_keep_po1", po1, 0);
    check("full_keep_po2", po2, 1);
    wr_valid = 0; start = 1; tick(); start = 0;
    wr_valid = 1; pi1 = 9; pi2 = 9; tick();
    wr_valid = 0; tick();
    check("restart_count", count, 2);
    check("restart_full", full, 0);
    check("restart_po1", po1, 9);
    check("restart_po2", po2, 9);
    rd_i = 1; tick();
    check("restart_rd1_po1", po1, 2);
    check("restart_rd1_po2", po2, 3);

    // Valid gaps over a complete run.
    start = 1; tick(); start = 0;
    for (int k = 0; k < 2*PAIRS; k++) begin
      wr_valid = (k % 2 == 0); pi1 = N'(100 + k); pi2 = N'(200 + k);
      tick();
    end
    wr_valid = 0;
    check("gap_count", count, R);
    for (int i = 0; i < PAIRS; i++) begin
      rd_i = 3'(i); tick();
      check("gap_rd_po1", po1, 100 + 2*i);
      check("gap_rd_po2", po2, 200 + 2*i);
    end

    // Reset mid-collection.
    start = 1; tick(); start = 0;
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1; pi1 = N'(k); pi2 = N'(k); tick();
    end
    wr_valid = 0; rst = 1; tick(); rst = 0;
    check("rst_count", count, 0);
    check("rst_ready", wr_ready, 0);
    start = 1; tick(); start = 0;
    wr_valid = 1; pi1 = 16'hA; pi2 = 16'hB; tick();
    wr_valid = 0; rd_i = 0; tick();
    check("rst_pair_count", count, 2);
    check("rst_pair_po1", po1, 16'hA);
    check("rst_pair_po2", po2, 16'hB);

    // Start beats valid; read-first collision.
    start = 1; tick(); start = 0;
    wr_valid = 1; pi1 = 16'h11; pi2 = 16'h22; tick();
    pi1 = 16'h33; pi2 = 16'h44; tick();
    start = 1; pi1 = 16'h55; pi2 = 16'h66; tick(); start = 0;
    check("startwin_count", count, 0);
    pi1 = 16'h1234; pi2 = 16'h5678; rd_i = 0; tick();
    check("rdfirst_old_po1", po1, 16'h11);
    check("rdfirst_old_po2", po2, 16'h22);
    wr_valid = 0; tick();
    check("rdfirst_new_po1", po1, 16'h1234);
    check("rdfirst_new_po2", po2, 16'h5678);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      rst      = ($urandom_range(0, 127) == 0);
      start    = ($urandom_range(0, 29) == 0);
      wr_valid = ($urandom_range(0, 3) != 0);
      pi1      = N'($urandom);
      pi2      = N'($urandom);
      rd_i     = 3'($urandom_range(0, PAIRS-1));
      tick();
    end
    rst = 0; start = 0; wr_valid = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
